// File: rtl/axi_adc_spi_pkg.sv
// Shared definitions for the AXI SPI ADC peripheral:
// register map, bit positions, FSM encodings and AXI response codes.
package axi_adc_spi_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_CLKDIV = 8'h04;
    localparam logic [7:0] REG_DATA   = 8'h08;
    localparam logic [7:0] REG_STATUS = 8'h0C;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_CH_LSB    = 2;
    localparam int CTRL_IRQ_BIT   = 5;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_OVR_BIT   = 1;

    localparam int DATA_VALID_BIT = 31;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        WRIDLE,
        WRDATA,
        WRRESP
    } wr_state_t;

    typedef enum logic {
        RDIDLE,
        RDDATA
    } rd_state_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } eng_state_t;

endpackage

// File: rtl/adc_spi_master.sv
// Single-frame SPI mode-0 engine: command word out on MOSI, result in on MISO.
// Half-period and channel are frozen at frame start.
module adc_spi_master
    import axi_adc_spi_pkg::*;
#(
    parameter int DATA_BITS  = 12,
    parameter int FRAME_BITS = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [2:0]           ch,
    input  logic [15:0]          div,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] sample,
    output logic                 spi_sclk,
    output logic                 spi_cs_n,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int BCW = $clog2(FRAME_BITS);

    eng_state_t            state;
    logic [15:0]           cnt;
    logic [15:0]           h;
    logic [BCW-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0] cmd;
    logic [FRAME_BITS-1:0] tx;
    logic [DATA_BITS-1:0]  rx;
    logic                  phase_end;

    assign cmd       = {1'b1, ch, {(FRAME_BITS-4){1'b0}}};
    assign phase_end = (cnt == h - 16'd1);
    assign busy      = (state != IDLE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            cnt      <= '0;
            h        <= 16'd1;
            bit_cnt  <= '0;
            tx       <= '0;
            rx       <= '0;
            done     <= 1'b0;
            sample   <= '0;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        cnt      <= '0;
                        h        <= (div == 16'd0) ? 16'd1 : div;
                        tx       <= {cmd[FRAME_BITS-2:0], 1'b0};
                        spi_cs_n <= 1'b0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= cmd[FRAME_BITS-1];
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        rx       <= {rx[DATA_BITS-2:0], spi_miso};
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (!phase_end) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= '0;
                        if (spi_sclk) begin
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx[FRAME_BITS-1];
                            tx       <= {tx[FRAME_BITS-2:0], 1'b0};
                        end else if (bit_cnt == BCW'(FRAME_BITS - 1)) begin
                            state <= HOLD;
                        end else begin
                            spi_sclk <= 1'b1;
                            rx       <= {rx[DATA_BITS-2:0], spi_miso};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        state    <= IDLE;
                        spi_cs_n <= 1'b1;
                        done     <= 1'b1;
                        sample   <= rx;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_adc_spi.sv
// AXI4-lite register front-end for the SPI ADC engine.
// Owns the sample buffer, VALID/OVERRUN flags and the completion interrupt.
module axi_adc_spi
    import axi_adc_spi_pkg::*;
#(
    parameter int C_ADDR_BITS = 8,
    parameter int DATA_BITS   = 12,
    parameter int FRAME_BITS  = 16,
    parameter int DIV_RESET   = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        adc_irq
);

    localparam logic [C_ADDR_BITS-1:0] A_CTRL   = C_ADDR_BITS'(REG_CTRL);
    localparam logic [C_ADDR_BITS-1:0] A_CLKDIV = C_ADDR_BITS'(REG_CLKDIV);
    localparam logic [C_ADDR_BITS-1:0] A_DATA   = C_ADDR_BITS'(REG_DATA);
    localparam logic [C_ADDR_BITS-1:0] A_STATUS = C_ADDR_BITS'(REG_STATUS);

    wr_state_t              wr_state;
    rd_state_t              rd_state;
    logic [C_ADDR_BITS-1:0] aw_addr;
    logic [C_ADDR_BITS-1:0] ar_addr;
    logic                   ctrl_cont;
    logic [2:0]             ctrl_ch;
    logic                   ctrl_irq_en;
    logic                   start_pulse;
    logic [15:0]            clkdiv;
    logic                   data_valid;
    logic [DATA_BITS-1:0]   data_sample;
    logic                   overrun;
    logic [31:0]            rd_mux;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   ovr_w1c;
    logic                   rd_data_hs;
    logic                   eng_busy;
    logic                   eng_done;
    logic [DATA_BITS-1:0]   eng_sample;
    logic                   unused_bits;

    assign ar_addr     = s_axi_araddr[C_ADDR_BITS-1:0];
    assign wr_fire     = s_axi_wvalid && s_axi_wready;
    assign rd_fire     = s_axi_arvalid && s_axi_arready;
    assign rd_data_hs  = rd_fire && (ar_addr == A_DATA);
    assign ovr_w1c     = wr_fire && (aw_addr == A_STATUS) &&
                         s_axi_wstrb[0] && s_axi_wdata[STAT_OVR_BIT];
    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;
    assign unused_bits = ^{s_axi_awaddr[31:C_ADDR_BITS],
                           s_axi_araddr[31:C_ADDR_BITS],
                           s_axi_wdata[31:16], s_axi_wstrb[3:2]};

    // done is a one-cycle registered pulse aligned with the cs_n rise
    assign adc_irq = eng_done && ctrl_irq_en;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state      <= WRIDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            aw_addr       <= '0;
            ctrl_cont     <= 1'b0;
            ctrl_ch       <= '0;
            ctrl_irq_en   <= 1'b0;
            start_pulse   <= 1'b0;
            clkdiv        <= 16'(DIV_RESET);
        end else begin
            start_pulse <= 1'b0;
            unique case (wr_state)
                WRIDLE: begin
                    if (s_axi_awvalid) begin
                        aw_addr       <= s_axi_awaddr[C_ADDR_BITS-1:0];
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        wr_state      <= WRDATA;
                    end
                end
                WRDATA: begin
                    if (s_axi_wvalid) begin
                        s_axi_wready <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        wr_state     <= WRRESP;
                        unique case (1'b1)
                            (aw_addr == A_CTRL): begin
                                if (s_axi_wstrb[0]) begin
                                    start_pulse <= s_axi_wdata[CTRL_START_BIT];
                                    ctrl_cont   <= s_axi_wdata[CTRL_CONT_BIT];
                                    ctrl_ch     <= s_axi_wdata[CTRL_CH_LSB +: 3];
                                    ctrl_irq_en <= s_axi_wdata[CTRL_IRQ_BIT];
                                end
                            end
                            (aw_addr == A_CLKDIV): begin
                                if (s_axi_wstrb[0]) clkdiv[7:0]  <= s_axi_wdata[7:0];
                                if (s_axi_wstrb[1]) clkdiv[15:8] <= s_axi_wdata[15:8];
                            end
                            default: ;
                        endcase
                    end
                end
                WRRESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        wr_state      <= WRIDLE;
                    end
                end
                default: wr_state <= WRIDLE;
            endcase
        end
    end

    // A completing frame beats a concurrent DATA read or OVERRUN clear
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            data_valid  <= 1'b0;
            data_sample <= '0;
            overrun     <= 1'b0;
        end else begin
            if (eng_done) begin
                data_sample <= eng_sample;
                data_valid  <= 1'b1;
            end else if (rd_data_hs) begin
                data_valid <= 1'b0;
            end
            if (eng_done && data_valid) begin
                overrun <= 1'b1;
            end else if (ovr_w1c) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (ar_addr == A_CTRL): begin
                rd_mux[CTRL_CONT_BIT]        = ctrl_cont;
                rd_mux[CTRL_CH_LSB +: 3]     = ctrl_ch;
                rd_mux[CTRL_IRQ_BIT]         = ctrl_irq_en;
            end
            (ar_addr == A_CLKDIV): rd_mux[15:0] = clkdiv;
            (ar_addr == A_DATA): begin
                rd_mux[DATA_BITS-1:0]        = data_sample;
                rd_mux[DATA_VALID_BIT]       = data_valid;
            end
            (ar_addr == A_STATUS): begin
                rd_mux[STAT_BUSY_BIT]        = eng_busy;
                rd_mux[STAT_OVR_BIT]         = overrun;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state      <= RDIDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            unique case (rd_state)
                RDIDLE: begin
                    if (s_axi_arvalid) begin
                        s_axi_rdata   <= rd_mux;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        rd_state      <= RDDATA;
                    end
                end
                RDDATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state      <= RDIDLE;
                    end
                end
                default: rd_state <= RDIDLE;
            endcase
        end
    end

    adc_spi_master #(
        .DATA_BITS  (DATA_BITS),
        .FRAME_BITS (FRAME_BITS)
    ) u_master (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start    (start_pulse || ctrl_cont),
        .ch       (ctrl_ch),
        .div      (clkdiv),
        .busy     (eng_busy),
        .done     (eng_done),
        .sample   (eng_sample),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

endmodule

// File: tb/tb_axi_adc_spi.sv
// Bench for axi_adc_spi: AXI-lite master tasks, SPI ADC slave model,
// and a frame monitor feeding a scoreboard of expected frames.
module tb_axi_adc_spi;

    typedef struct {
        logic [15:0] mosi;
        int          cs_low;
        int          hi;
    } exp_t;

    typedef struct {
        logic [15:0] mosi;
        int          cs_low;
        int          pulses;
        int          hi_min;
        int          hi_max;
        logic        irq_rise;
    } frame_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic        adc_irq;

    int checks = 0;
    int errors = 0;

    exp_t   exp_q[$];
    frame_t obs_q[$];

    logic [15:0] adc_value = 16'h0000;
    logic [15:0] slv_sr = '0;
    logic [15:0] mosi_w = '0;
    logic        in_frame = 1'b0;
    logic        sclk_prev = 1'b0;
    int          cs_low, pulses, hi_run, hi_min, hi_max;
    int          frame_count = 0;
    int          irq_total = 0;

    axi_adc_spi dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .adc_irq       (adc_irq)
    );

    always #5 aclk = ~aclk;

    // ADC slave model and frame monitor, sampled mid-cycle
    always @(negedge aclk) begin
        if (!aresetn) begin
            in_frame = 1'b0;
            spi_miso = 1'b0;
        end else begin
            if (adc_irq) irq_total++;
            if (!spi_cs_n) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cs_low = 0; pulses = 0; hi_run = 0;
                    hi_min = 1000; hi_max = 0; mosi_w = '0;
                    slv_sr = adc_value;
                    spi_miso = slv_sr[15];
                end else if (sclk_prev && !spi_sclk) begin
                    slv_sr = {slv_sr[14:0], 1'b0};
                    spi_miso = slv_sr[15];
                end
                cs_low++;
                if (spi_sclk) begin
                    hi_run++;
                    if (!sclk_prev) begin
                        pulses++;
                        mosi_w = {mosi_w[14:0], spi_mosi};
                    end
                end else if (sclk_prev) begin
                    if (hi_run < hi_min) hi_min = hi_run;
                    if (hi_run > hi_max) hi_max = hi_run;
                    hi_run = 0;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                obs_q.push_back('{mosi_w, cs_low, pulses, hi_min, hi_max, adc_irq});
                frame_count++;
            end
        end
        sclk_prev = spi_sclk;
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int n;
        @(negedge aclk);
        s_axi_awaddr = a; s_axi_awvalid = 1'b1; n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout addr=%h", a); end
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1; n = 0;
        while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout addr=%h", a); end
        @(negedge aclk);
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL b_timeout addr=%h", a); end
        @(negedge aclk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(negedge aclk);
        s_axi_araddr = a; s_axi_arvalid = 1'b1; n = 0;
        while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout addr=%h", a); end
        @(negedge aclk);
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1; n = 0;
        while (!s_axi_rvalid && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL r_timeout addr=%h", a); end
        d = s_axi_rdata;
        @(negedge aclk);
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int c;
        c = 0;
        while (obs_q.size() < n && c < 3000) begin @(negedge aclk); c++; end
        if (obs_q.size() < n) begin
            checks++; errors++;
            $display("FAIL frame_timeout got=%0d need=%0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        aresetn = 1'b0;
        repeat (4) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if ({spi_cs_n, spi_sclk, spi_mosi, adc_irq} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_spi got=%b need=1000", {spi_cs_n, spi_sclk, spi_mosi, adc_irq});
        end
        checks++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_axi got=%b need=11000",
                     {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid});
        end
        checks++;
        if (s_axi_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h need=00000000", s_axi_rdata);
        end
        axi_read(32'h04, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL reset_clkdiv got=%h need=00000004", d); end
        axi_read(32'h0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%h need=00000000", d); end
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_data got=%h need=00000000", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        exp_t   e;
        frame_t o;
        adc_value = 16'h0ABC;
        axi_write(32'h04, 32'h2, 4'hF);
        exp_q.push_back('{16'hB000, 68, 2});
        axi_write(32'h00, 32'h0D, 4'hF);
        wait_obs(1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.mosi !== e.mosi || o.cs_low != e.cs_low || o.pulses != 16 ||
                o.hi_min != e.hi || o.hi_max != e.hi || o.irq_rise !== 1'b0) begin
                errors++;
                $display("FAIL single_frame mosi=%h/%h cs_low=%0d/%0d pulses=%0d/16 hi=%0d..%0d/%0d irq=%b/0",
                         o.mosi, e.mosi, o.cs_low, e.cs_low, o.pulses, o.hi_min, o.hi_max, e.hi, o.irq_rise);
            end
        end
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h80000ABC) begin errors++; $display("FAIL single_data got=%h need=80000abc", d); end
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h00000ABC) begin errors++; $display("FAIL single_reread got=%h need=00000abc", d); end
        axi_read(32'h00, d);
        checks++;
        if (d !== 32'h0C) begin errors++; $display("FAIL ctrl_readback got=%h need=0000000c", d); end
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        exp_t   e;
        frame_t o;
        int     fc0;
        adc_value = 16'h0123;
        fc0 = frame_count;
        for (int i = 0; i < 3; i++) exp_q.push_back('{16'h8000, 68, 2});
        axi_write(32'h00, 32'h02, 4'hF);
        wait_obs(3);
        for (int i = 0; i < 3; i++) begin
            if (obs_q.size() != 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                checks++;
                if (o.mosi !== e.mosi || o.cs_low != e.cs_low || o.pulses != 16) begin
                    errors++;
                    $display("FAIL cont_frame%0d mosi=%h/%h cs_low=%0d/%0d pulses=%0d/16",
                             i, o.mosi, e.mosi, o.cs_low, e.cs_low, o.pulses);
                end
            end
        end
        axi_read(32'h0C, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL cont_overrun got=%h need=00000003", d); end
        axi_write(32'h0C, 32'h2, 4'h1);
        axi_read(32'h0C, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL ovr_clear got=%h need=00000001", d); end
        exp_q.push_back('{16'h8000, 68, 2});
        axi_write(32'h00, 32'h00, 4'hF);
        wait_obs(1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.mosi !== e.mosi || o.cs_low != e.cs_low) begin
                errors++;
                $display("FAIL cont_last mosi=%h/%h cs_low=%0d/%0d", o.mosi, e.mosi, o.cs_low, e.cs_low);
            end
        end
        repeat (150) @(negedge aclk);
        checks++;
        if (frame_count - fc0 != 4) begin
            errors++; $display("FAIL cont_stop frames=%0d need=4", frame_count - fc0);
        end
        axi_read(32'h0C, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL cont_idle got=%h need=00000002", d); end
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h80000123) begin errors++; $display("FAIL cont_data got=%h need=80000123", d); end
    endtask

    task automatic test_start_busy();
        logic [31:0] d;
        exp_t   e;
        frame_t o;
        int     fc0;
        adc_value = 16'h0FFF;
        axi_write(32'h0C, 32'h2, 4'h1);
        fc0 = frame_count;
        exp_q.push_back('{16'hF000, 68, 2});
        axi_write(32'h00, 32'h1D, 4'hF);
        repeat (10) @(negedge aclk);
        axi_read(32'h0C, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL busy_status got=%h need=00000001", d); end
        axi_write(32'h00, 32'h1D, 4'hF);
        wait_obs(1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.mosi !== e.mosi || o.cs_low != e.cs_low || o.pulses != 16) begin
                errors++;
                $display("FAIL busy_frame mosi=%h/%h cs_low=%0d/%0d pulses=%0d/16",
                         o.mosi, e.mosi, o.cs_low, e.cs_low, o.pulses);
            end
        end
        repeat (150) @(negedge aclk);
        checks++;
        if (frame_count - fc0 != 1) begin
            errors++; $display("FAIL busy_frames got=%0d need=1", frame_count - fc0);
        end
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h80000FFF) begin errors++; $display("FAIL busy_data got=%h need=80000fff", d); end
    endtask

    task automatic test_irq();
        exp_t   e;
        frame_t o;
        int     irq0;
        adc_value = 16'h0555;
        irq0 = irq_total;
        exp_q.push_back('{16'h8000, 68, 2});
        axi_write(32'h00, 32'h21, 4'hF);
        wait_obs(1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.mosi !== e.mosi || o.irq_rise !== 1'b1) begin
                errors++;
                $display("FAIL irq_on mosi=%h/%h irq_at_cs_rise=%b/1", o.mosi, e.mosi, o.irq_rise);
            end
        end
        repeat (5) @(negedge aclk);
        checks++;
        if (irq_total - irq0 != 1) begin
            errors++; $display("FAIL irq_width cycles=%0d need=1", irq_total - irq0);
        end
        exp_q.push_back('{16'h8000, 68, 2});
        axi_write(32'h00, 32'h01, 4'hF);
        wait_obs(1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.mosi !== e.mosi || o.irq_rise !== 1'b0) begin
                errors++;
                $display("FAIL irq_off mosi=%h/%h irq_at_cs_rise=%b/0", o.mosi, e.mosi, o.irq_rise);
            end
        end
        repeat (5) @(negedge aclk);
        checks++;
        if (irq_total - irq0 != 1) begin
            errors++; $display("FAIL irq_off_count cycles=%0d need=1", irq_total - irq0);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] d;
        exp_t   e;
        frame_t o;
        adc_value = 16'hF5A5;
        axi_read(32'h08, d);
        axi_write(32'h04, 32'h0, 4'h3);
        axi_read(32'h04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL div0_read got=%h need=00000000", d); end
        exp_q.push_back('{16'hD000, 34, 1});
        axi_write(32'h00, 32'h15, 4'hF);
        wait_obs(1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.mosi !== e.mosi || o.cs_low != e.cs_low || o.pulses != 16 ||
                o.hi_min != e.hi || o.hi_max != e.hi) begin
                errors++;
                $display("FAIL div0_frame mosi=%h/%h cs_low=%0d/%0d pulses=%0d/16 hi=%0d..%0d/%0d",
                         o.mosi, e.mosi, o.cs_low, e.cs_low, o.pulses, o.hi_min, o.hi_max, e.hi);
            end
        end
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h800005A5) begin errors++; $display("FAIL div0_data got=%h need=800005a5", d); end
    endtask

    task automatic test_strobe_map();
        logic [31:0] d;
        axi_write(32'h04, 32'h1234, 4'h2);
        axi_write(32'h04, 32'hFF56, 4'h1);
        axi_read(32'h04, d);
        checks++;
        if (d !== 32'h1256) begin errors++; $display("FAIL clkdiv_strb got=%h need=00001256", d); end
        axi_write(32'h00, 32'h03, 4'h0);
        axi_read(32'h00, d);
        checks++;
        if (d !== 32'h14) begin errors++; $display("FAIL ctrl_strb got=%h need=00000014", d); end
        axi_read(32'h10, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped got=%h need=00000000", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int c;
        adc_value = 16'h0777;
        axi_write(32'h04, 32'h2, 4'h3);
        axi_write(32'h00, 32'h01, 4'hF);
        c = 0;
        while (!spi_sclk && c < 200) begin @(negedge aclk); c++; end
        checks++;
        if (!spi_sclk) begin errors++; $display("FAIL mid_no_shift sclk=%b need=1", spi_sclk); end
        repeat (3) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        checks++;
        if ({spi_cs_n, spi_sclk} !== 2'b10) begin
            errors++; $display("FAIL mid_abort cs_n,sclk=%b need=10", {spi_cs_n, spi_sclk});
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_data got=%h need=00000000", d); end
        axi_read(32'h04, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL mid_clkdiv got=%h need=00000004", d); end
        repeat (100) @(negedge aclk);
        checks++;
        if (obs_q.size() != 0 || spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_frame frames=%0d cs_n=%b need=0,1", obs_q.size(), spi_cs_n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_start_busy();
        test_irq();
        test_div_zero();
        test_strobe_map();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
